// File: rtl/ifetch_queue.sv
// Fetch-side request engine: issues one I-cache read per PC, advances the PC on
// each accepted response and buffers {pc, instruction} pairs for decode.
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             flush,
  output logic             load_pc,
  output logic             icache_read,
  output logic [WIDTH-1:0] icache_address,
  input  logic             icache_resp,
  input  logic [WIDTH-1:0] icache_rdata,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               read_q, read_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   inst_mem_q [DEPTH];
  logic [WIDTH-1:0]   pc_mem_q   [DEPTH];
  logic               push;
  logic               pop;

  assign icache_read    = read_q;
  assign icache_address = addr_q;
  assign inst_valid     = (count_q != '0);
  assign inst_out       = inst_mem_q[head_q];
  assign inst_pc        = pc_mem_q[head_q];

  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    addr_d  = addr_q;
    load_pc = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && (count_q < CNT_W'(DEPTH))) begin
          read_d  = 1'b1;
          addr_d  = pc_in;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (icache_resp) begin
          load_pc = !flush;
          read_d  = 1'b0;
          state_d = IDLE;
        end else if (flush) begin
          // The read cannot be cancelled; keep requesting and drop its data later.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (icache_resp) begin
          read_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        read_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign push = load_pc;
  assign pop  = inst_valid && inst_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
      head_d  = tail_q;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      addr_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; contents are only observed while inst_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[tail_q] <= icache_rdata;
      pc_mem_q[tail_q]   <= addr_q;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: reset, fill/backpressure, flush in WAIT,
// flush with response, push+pop with wrap-around, and reset mid-request.
module tb_ifetch_queue;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] pc_in;
  logic             flush;
  logic             load_pc;
  logic             icache_read;
  logic [WIDTH-1:0] icache_address;
  logic             icache_resp;
  logic [WIDTH-1:0] icache_rdata;
  logic             inst_valid;
  logic [WIDTH-1:0] inst_out;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_ready;

  int checks = 0;
  int errors = 0;

  ifetch_queue #(.DEPTH(4), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .flush          (flush),
    .load_pc        (load_pc),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_resp    (icache_resp),
    .icache_rdata   (icache_rdata),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; pc_in = 32'h60; flush = 0; icache_resp = 0; icache_rdata = 0; inst_ready = 0;
    #2 rst = 1'b0;
    tick; tick;
    checks++; if (icache_read !== 1'b0) begin errors++; $display("FAIL reset_read got=%b exp=0", icache_read); end
    checks++; if (icache_address !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", icache_address); end
    checks++; if (load_pc !== 1'b0) begin errors++; $display("FAIL reset_load_pc got=%b exp=0", load_pc); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    $display("reset: read=%b addr=%h valid=%b", icache_read, icache_address, inst_valid);
    rst = 1'b1;
    tick;
    checks++; if (icache_read !== 1'b1) begin errors++; $display("FAIL first_read got=%b exp=1", icache_read); end
    checks++; if (icache_address !== 32'h60) begin errors++; $display("FAIL first_addr got=%h exp=60", icache_address); end
    tick;
    checks++; if (load_pc !== 1'b0) begin errors++; $display("FAIL first_wait_load_pc got=%b exp=0", load_pc); end
    icache_resp = 1; icache_rdata = 32'h00000013; #1;
    checks++; if (load_pc !== 1'b1) begin errors++; $display("FAIL first_load_pc got=%b exp=1", load_pc); end
    tick; icache_resp = 0; pc_in = 32'h64; #1;
    checks++; if (load_pc !== 1'b0) begin errors++; $display("FAIL first_load_pc_after got=%b exp=0", load_pc); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", inst_valid); end
    checks++; if (inst_pc !== 32'h60) begin errors++; $display("FAIL first_inst_pc got=%h exp=60", inst_pc); end
    checks++; if (inst_out !== 32'h13) begin errors++; $display("FAIL first_inst_out got=%h exp=13", inst_out); end
    checks++; if (icache_read !== 1'b0) begin errors++; $display("FAIL first_read_drop got=%b exp=0", icache_read); end
    $display("first fetch: pc=%h inst=%h", inst_pc, inst_out);
  endtask

  task automatic test_fill;
    logic [31:0] a;
    for (int k = 1; k < 4; k++) begin
      a = 32'h60 + 32'(4 * k);
      tick;
      checks++; if (icache_read !== 1'b1 || icache_address !== a) begin errors++; $display("FAIL fill_req%0d read=%b addr=%h exp addr=%h", k, icache_read, icache_address, a); end
      icache_resp = 1; icache_rdata = 32'h13 + 32'(k); #1;
      checks++; if (load_pc !== 1'b1) begin errors++; $display("FAIL fill_load_pc%0d got=%b exp=1", k, load_pc); end
      tick; icache_resp = 0; pc_in = a + 32'h4;
      $display("fill: queued pc=%h", a);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (icache_read !== 1'b0) begin errors++; $display("FAIL full_read%0d got=%b exp=0", k, icache_read); end
      checks++; if (inst_pc !== 32'h60) begin errors++; $display("FAIL full_head%0d got=%h exp=60", k, inst_pc); end
    end
    inst_ready = 1;
    tick; inst_ready = 0;
    checks++; if (inst_pc !== 32'h64 || inst_out !== 32'h14) begin errors++; $display("FAIL pop_head pc=%h inst=%h exp 64/14", inst_pc, inst_out); end
    checks++; if (icache_read !== 1'b0) begin errors++; $display("FAIL pop_same_cycle_read got=%b exp=0", icache_read); end
    tick;
    checks++; if (icache_read !== 1'b1 || icache_address !== 32'h70) begin errors++; $display("FAIL refill_req read=%b addr=%h exp 1/70", icache_read, icache_address); end
    icache_resp = 1; icache_rdata = 32'h17;
    tick; icache_resp = 0; pc_in = 32'h100; flush = 1;
    tick; flush = 0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL idle_flush_valid got=%b exp=0", inst_valid); end
    checks++; if (icache_read !== 1'b0) begin errors++; $display("FAIL idle_flush_read got=%b exp=0", icache_read); end
    $display("fill: backpressure and refill at 70 done, queue flushed");
  endtask

  task automatic test_flush_wait;
    tick;
    checks++; if (icache_read !== 1'b1 || icache_address !== 32'h100) begin errors++; $display("FAIL fw_req read=%b addr=%h exp 1/100", icache_read, icache_address); end
    flush = 1; #1;
    checks++; if (load_pc !== 1'b0) begin errors++; $display("FAIL fw_load_pc got=%b exp=0", load_pc); end
    tick; flush = 0; pc_in = 32'h200;
    checks++; if (icache_read !== 1'b1 || icache_address !== 32'h100) begin errors++; $display("FAIL drain_hold read=%b addr=%h exp 1/100", icache_read, icache_address); end
    flush = 1;
    tick; flush = 0;
    checks++; if (icache_read !== 1'b1) begin errors++; $display("FAIL drain_reflush_read got=%b exp=1", icache_read); end
    tick;
    icache_resp = 1; icache_rdata = 32'hDEADBEEF; #1;
    checks++; if (load_pc !== 1'b0) begin errors++; $display("FAIL drain_load_pc got=%b exp=0", load_pc); end
    tick; icache_resp = 0;
    checks++; if (icache_read !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL drain_done read=%b valid=%b exp 0/0", icache_read, inst_valid); end
    tick;
    checks++; if (icache_read !== 1'b1 || icache_address !== 32'h200) begin errors++; $display("FAIL redirect_req read=%b addr=%h exp 1/200", icache_read, icache_address); end
    icache_resp = 1; icache_rdata = 32'h11111111;
    tick; icache_resp = 0; pc_in = 32'h204;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst_out !== 32'h11111111) begin errors++; $display("FAIL redirect_entry valid=%b pc=%h inst=%h", inst_valid, inst_pc, inst_out); end
    $display("flush in WAIT: dropped DEADBEEF, redirected fetch pc=%h", inst_pc);
  endtask

  task automatic test_flush_with_resp;
    tick;
    icache_resp = 1; icache_rdata = 32'h2222;
    tick; icache_resp = 0; pc_in = 32'h208;
    tick;
    checks++; if (icache_address !== 32'h208) begin errors++; $display("FAIL fr_req addr=%h exp 208", icache_address); end
    icache_resp = 1; icache_rdata = 32'h5555; flush = 1; #1;
    checks++; if (load_pc !== 1'b0) begin errors++; $display("FAIL fr_load_pc got=%b exp=0", load_pc); end
    tick; icache_resp = 0; flush = 0; pc_in = 32'h300;
    checks++; if (inst_valid !== 1'b0 || icache_read !== 1'b0) begin errors++; $display("FAIL fr_cleared valid=%b read=%b exp 0/0", inst_valid, icache_read); end
    tick;
    checks++; if (icache_read !== 1'b1 || icache_address !== 32'h300) begin errors++; $display("FAIL fr_next_req read=%b addr=%h exp 1/300", icache_read, icache_address); end
    icache_resp = 1; icache_rdata = 32'h3333;
    tick; icache_resp = 0; pc_in = 32'h304;
    checks++; if (inst_pc !== 32'h300 || inst_out !== 32'h3333) begin errors++; $display("FAIL fr_entry pc=%h inst=%h exp 300/3333", inst_pc, inst_out); end
    $display("flush with resp: queue cleared, next pc=%h", inst_pc);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    tick;
    icache_resp = 1; icache_rdata = 32'h4444; inst_ready = 1; #1;
    checks++; if (load_pc !== 1'b1) begin errors++; $display("FAIL pp_load_pc got=%b exp=1", load_pc); end
    tick; icache_resp = 0; inst_ready = 0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h304 || inst_out !== 32'h4444) begin errors++; $display("FAIL pp_entry valid=%b pc=%h inst=%h", inst_valid, inst_pc, inst_out); end
    for (int i = 0; i < 9; i++) begin
      a = 32'h308 + 32'(4 * i);
      pc_in = a;
      tick;
      icache_resp = 1; icache_rdata = 32'hA000 + 32'(i); inst_ready = 1;
      tick; icache_resp = 0; inst_ready = 0;
      checks++; if (inst_pc !== a || inst_out !== 32'hA000 + 32'(i)) begin errors++; $display("FAIL wrap%0d pc=%h inst=%h exp %h/%h", i, inst_pc, inst_out, a, 32'hA000 + 32'(i)); end
      $display("wrap %0d: head pc=%h inst=%h", i, inst_pc, inst_out);
    end
    pc_in = 32'h400; inst_ready = 1;
    tick; inst_ready = 0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL pp_count_one valid=%b exp=0", inst_valid); end
    checks++; if (icache_read !== 1'b1 || icache_address !== 32'h400) begin errors++; $display("FAIL pp_next_req read=%b addr=%h exp 1/400", icache_read, icache_address); end
  endtask

  task automatic test_reset_in_wait;
    rst = 1'b0; #1;
    checks++; if (icache_read !== 1'b0 || icache_address !== 32'h0) begin errors++; $display("FAIL rw_outputs read=%b addr=%h exp 0/0", icache_read, icache_address); end
    checks++; if (inst_valid !== 1'b0 || load_pc !== 1'b0) begin errors++; $display("FAIL rw_valid valid=%b load_pc=%b exp 0/0", inst_valid, load_pc); end
    tick;
    rst = 1'b1; icache_resp = 1; icache_rdata = 32'hBAD0BAD0; #1;
    checks++; if (load_pc !== 1'b0) begin errors++; $display("FAIL rw_stray_load_pc got=%b exp=0", load_pc); end
    tick; icache_resp = 0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_stray_queued valid=%b exp=0", inst_valid); end
    checks++; if (icache_read !== 1'b1 || icache_address !== 32'h400) begin errors++; $display("FAIL rw_reissue read=%b addr=%h exp 1/400", icache_read, icache_address); end
    $display("reset in WAIT: stray resp ignored, reissued addr=%h", icache_address);
  endtask

  initial begin
    test_reset;
    test_fill;
    test_flush_wait;
    test_flush_with_resp;
    test_back_to_back;
    test_reset_in_wait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
